// File: rtl/chr_bg_layer_if.sv
// Pixel request/result bundle between the video timing counter and the background layer.
// The master issues screen coordinates; the slave returns the coloured pixel a fixed number of clocks later.
interface chr_bg_layer_if #(
  parameter int COORD_BITS = 16,
  parameter int BPP        = 8
);
  logic                  in_valid;
  logic [COORD_BITS-1:0] count_h;
  logic [COORD_BITS-1:0] count_v;
  logic                  out_valid;
  logic [BPP-1:0]        color;
  logic                  opaque;

  modport master (output in_valid, count_h, count_v, input out_valid, color, opaque);
  modport slave  (input in_valid, count_h, count_v, output out_valid, color, opaque);
endinterface

// File: rtl/chr_bg_layer.sv
// Tile/character background layer: scroll, scale, map/pattern/palette lookup, one pixel per clock.
// Latency 7 clocks from request to result; never stalls, so no backpressure is applied to the requester.
module chr_bg_layer #(
  parameter int MAP_W_BITS     = 6,
  parameter int MAP_H_BITS     = 6,
  parameter int TILE_BITS      = 3,
  parameter int PIX_BITS       = 2,
  parameter int CHR_BITS       = 8,
  parameter int PAL_SEL_BITS   = 2,
  parameter int BPP            = 8,
  parameter int COORD_BITS     = 16,
  parameter int SCALE_DIV_BITS = 8
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [MAP_W_BITS+MAP_H_BITS-1:0]   map_addr,
  input  logic [CHR_BITS-1:0]                map_din,
  input  logic                               map_we,
  input  logic [CHR_BITS+2*TILE_BITS-1:0]    pat_addr,
  input  logic [PIX_BITS-1:0]                pat_din,
  input  logic                               pat_we,
  input  logic [PAL_SEL_BITS+PIX_BITS-1:0]   pal_addr,
  input  logic [BPP-1:0]                     pal_din,
  input  logic                               pal_we,
  input  logic [COORD_BITS-1:0]              x,
  input  logic [COORD_BITS-1:0]              y,
  input  logic [3:0]                         scale,
  input  logic                               wrap_en,
  input  logic                               transp_en,
  input  logic                               ctrl_load,
  chr_bg_layer_if.slave                      pix_if
);

  localparam int MAP_AW = MAP_W_BITS + MAP_H_BITS;
  localparam int PAT_AW = CHR_BITS + 2*TILE_BITS;
  localparam int PAL_AW = PAL_SEL_BITS + PIX_BITS;
  localparam int DW     = COORD_BITS + 1;
  localparam int SW     = COORD_BITS + 16;

  logic [COORD_BITS-1:0] sh_x, sh_y;
  logic [3:0]            sh_scale;
  logic                  sh_wrap, sh_transp;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sh_x      <= '0;
      sh_y      <= '0;
      sh_scale  <= 4'(SCALE_DIV_BITS);
      sh_wrap   <= 1'b1;
      sh_transp <= 1'b0;
    end else if (ctrl_load) begin
      sh_x      <= x;
      sh_y      <= y;
      sh_scale  <= scale;
      sh_wrap   <= wrap_en;
      sh_transp <= transp_en;
    end
  end

  logic v1, v2, v3, v4, v5, v6, v7;
  logic out_valid_q, opaque_q;
  logic [BPP-1:0] color_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      {v1, v2, v3, v4, v5, v6, v7} <= '0;
      out_valid_q <= 1'b0;
      opaque_q    <= 1'b0;
      color_q     <= '0;
    end else begin
      v1 <= pix_if.in_valid;
      v2 <= v1;
      v3 <= v2;
      v4 <= v3;
      v5 <= v4;
      v6 <= v5;
      v7 <= v6;
      out_valid_q <= v7;
      opaque_q    <= v7 & op7;
      color_q     <= (v7 & op7) ? pal_q7 : '0;
    end
  end

  // Controls travel with each pixel so a load mid-flight never affects pixels already issued.
  logic [DW-1:0]           dx1, dy1;
  logic [3:0]              sc1;
  logic                    wr1, tr1, wr2, tr2, tr3, tr4, tr5, tr6;
  logic [SW-1:0]           sx2, sy2;
  logic [MAP_AW-1:0]       map_ra3;
  logic [TILE_BITS-1:0]    subx3, suby3, subx4, suby4;
  logic                    in3, in4, in5, in6, op7;
  logic [PAT_AW-1:0]       pat_ra5;
  logic [PAL_SEL_BITS-1:0] bank5, bank6;
  logic [CHR_BITS-1:0]     name4;
  logic [PIX_BITS-1:0]     pix6;
  logic [BPP-1:0]          pal_q7;

  logic [SW-1:0]        dx_ext, dy_ext, sx_c, sy_c;
  logic signed [SW-1:0] dx_shl, dy_shl;
  logic                 in_x, in_y;

  always_comb begin
    dx_ext = {{(SW-DW){dx1[DW-1]}}, dx1};
    dy_ext = {{(SW-DW){dy1[DW-1]}}, dy1};
    dx_shl = $signed(dx_ext << sc1);
    dy_shl = $signed(dy_ext << sc1);
    sx_c   = dx_shl >>> SCALE_DIV_BITS;
    sy_c   = dy_shl >>> SCALE_DIV_BITS;
    // Inside the map exactly when every bit above the tile index, sign included, is zero.
    in_x   = (sx2[SW-1:TILE_BITS+MAP_W_BITS] == '0);
    in_y   = (sy2[SW-1:TILE_BITS+MAP_H_BITS] == '0);
  end

  always_ff @(posedge clk) begin
    dx1 <= {pix_if.count_h[COORD_BITS-1], pix_if.count_h} - {sh_x[COORD_BITS-1], sh_x};
    dy1 <= {pix_if.count_v[COORD_BITS-1], pix_if.count_v} - {sh_y[COORD_BITS-1], sh_y};
    sc1 <= sh_scale;
    wr1 <= sh_wrap;
    tr1 <= sh_transp;

    sx2 <= sx_c;
    sy2 <= sy_c;
    wr2 <= wr1;
    tr2 <= tr1;

    map_ra3 <= {sy2[TILE_BITS+MAP_H_BITS-1:TILE_BITS], sx2[TILE_BITS+MAP_W_BITS-1:TILE_BITS]};
    subx3   <= sx2[TILE_BITS-1:0];
    suby3   <= sy2[TILE_BITS-1:0];
    in3     <= wr2 | (in_x & in_y);
    tr3     <= tr2;

    subx4 <= subx3;
    suby4 <= suby3;
    in4   <= in3;
    tr4   <= tr3;

    pat_ra5 <= {name4, suby4, subx4};
    bank5   <= name4[CHR_BITS-1 -: PAL_SEL_BITS];
    in5     <= in4;
    tr5     <= tr4;

    bank6 <= bank5;
    in6   <= in5;
    tr6   <= tr5;

    op7 <= in6 & ~(tr6 & (pix6 == '0));
  end

  // Simple dual-port RAMs; read-first falls out of the shared non-blocking edge.
  logic [CHR_BITS-1:0] map_mem [2**MAP_AW];
  logic [PIX_BITS-1:0] pat_mem [2**PAT_AW];
  logic [BPP-1:0]      pal_mem [2**PAL_AW];

  always_ff @(posedge clk) begin
    if (map_we) map_mem[map_addr] <= map_din;
    name4 <= map_mem[map_ra3];
  end

  always_ff @(posedge clk) begin
    if (pat_we) pat_mem[pat_addr] <= pat_din;
    pix6 <= pat_mem[pat_ra5];
  end

  always_ff @(posedge clk) begin
    if (pal_we) pal_mem[pal_addr] <= pal_din;
    pal_q7 <= pal_mem[{bank6, pix6}];
  end

  assign pix_if.out_valid = out_valid_q;
  assign pix_if.color     = color_q;
  assign pix_if.opaque    = opaque_q;

endmodule

// File: tb/tb_chr_bg_layer.sv
// Directed bench for chr_bg_layer: stimulus pushes expected pixels, a monitor pops and compares.
module tb_chr_bg_layer;

  logic        clk = 1'b0;
  logic        reset;
  logic [11:0] map_addr;
  logic [7:0]  map_din;
  logic        map_we;
  logic [13:0] pat_addr;
  logic [1:0]  pat_din;
  logic        pat_we;
  logic [3:0]  pal_addr;
  logic [7:0]  pal_din;
  logic        pal_we;
  logic [15:0] x, y;
  logic [3:0]  scale;
  logic        wrap_en, transp_en, ctrl_load;

  chr_bg_layer_if #(.COORD_BITS(16), .BPP(8)) pif ();

  chr_bg_layer dut (
    .clk(clk), .reset(reset),
    .map_addr(map_addr), .map_din(map_din), .map_we(map_we),
    .pat_addr(pat_addr), .pat_din(pat_din), .pat_we(pat_we),
    .pal_addr(pal_addr), .pal_din(pal_din), .pal_we(pal_we),
    .x(x), .y(y), .scale(scale), .wrap_en(wrap_en), .transp_en(transp_en),
    .ctrl_load(ctrl_load), .pix_if(pif)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [7:0]  col;
    logic        op;
    logic [31:0] cyc;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   fails   = 0;
  logic mon_en  = 1'b0;

  task automatic chk(input string name, input int act, input int exp_v);
    vectors++;
    if (act != exp_v) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp_v);
    end
  endtask

  task automatic req(input logic [15:0] h, input logic [15:0] v, input logic [7:0] col,
                     input logic op, input logic ld);
    exp_t e;
    @(negedge clk);
    ctrl_load    = ld;
    pif.in_valid = 1'b1;
    pif.count_h  = h;
    pif.count_v  = v;
    e.col = col;
    e.op  = op;
    e.cyc = cyc + 1;
    sb.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      pif.in_valid = 1'b0;
      ctrl_load    = 1'b0;
    end
  endtask

  task automatic map_wr(input logic [11:0] a, input logic [7:0] d);
    @(negedge clk);
    pif.in_valid = 1'b0;
    map_we = 1'b1; map_addr = a; map_din = d;
    @(negedge clk);
    map_we = 1'b0;
  endtask

  task automatic pat_wr(input logic [7:0] name, input logic [2:0] py, input logic [2:0] px,
                        input logic [1:0] d);
    @(negedge clk);
    pif.in_valid = 1'b0;
    pat_we = 1'b1; pat_addr = {name, py, px}; pat_din = d;
    @(negedge clk);
    pat_we = 1'b0;
  endtask

  task automatic pal_wr(input logic [3:0] a, input logic [7:0] d);
    @(negedge clk);
    pif.in_valid = 1'b0;
    pal_we = 1'b1; pal_addr = a; pal_din = d;
    @(negedge clk);
    pal_we = 1'b0;
  endtask

  task automatic load(input logic [15:0] xx, input logic [15:0] yy, input logic [3:0] sc,
                      input logic wr, input logic tr);
    @(negedge clk);
    pif.in_valid = 1'b0;
    x = xx; y = yy; scale = sc; wrap_en = wr; transp_en = tr;
    ctrl_load = 1'b1;
    @(negedge clk);
    ctrl_load = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, required finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    map_addr = '0; map_din = '0; map_we = 1'b0;
    pat_addr = '0; pat_din = '0; pat_we = 1'b0;
    pal_addr = '0; pal_din = '0; pal_we = 1'b0;
    x = '0; y = '0; scale = 4'd8; wrap_en = 1'b1; transp_en = 1'b0; ctrl_load = 1'b0;
    pif.in_valid = 1'b0; pif.count_h = '0; pif.count_v = '0;

    fork
      begin : stim
        int rel;
        int lat;
        repeat (3) @(negedge clk);
        chk("reset_out_valid", int'(pif.out_valid), 0);
        chk("reset_color", int'(pif.color), 0);
        chk("reset_opaque", int'(pif.opaque), 0);

        // Reset dropped in the middle of a stream of requests.
        @(negedge clk);
        reset = 1'b0;
        pif.in_valid = 1'b1; pif.count_h = 16'd3; pif.count_v = 16'd2;
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("midreset_out_valid", int'(pif.out_valid), 0);
        chk("midreset_color", int'(pif.color), 0);
        chk("midreset_opaque", int'(pif.opaque), 0);
        @(negedge clk);
        reset = 1'b0;
        rel = int'(cyc);
        lat = -1;
        for (int i = 0; i < 20; i++) begin
          @(negedge clk);
          if (pif.out_valid) begin
            lat = int'(cyc) - rel - 1;
            break;
          end
        end
        chk("first_latency", lat, 7);
        idle(12);
        mon_en = 1'b1;

        map_wr(12'd0, 8'h41);
        map_wr(12'd63, 8'h82);
        map_wr(12'd4, 8'hC3);
        pat_wr(8'h41, 3'd2, 3'd3, 2'd2);
        pat_wr(8'h41, 3'd0, 3'd0, 2'd0);
        pat_wr(8'h82, 3'd2, 3'd3, 2'd1);
        pat_wr(8'h82, 3'd0, 3'd7, 2'd3);
        pat_wr(8'h82, 3'd2, 3'd7, 2'd3);
        pat_wr(8'h82, 3'd2, 3'd1, 2'd0);
        pat_wr(8'hC3, 3'd0, 3'd0, 2'd1);
        pat_wr(8'hC3, 3'd0, 3'd2, 2'd2);
        pal_wr(4'd6, 8'hA5);
        pal_wr(4'd4, 8'h11);
        pal_wr(4'd9, 8'h3C);
        pal_wr(4'd11, 8'h77);
        pal_wr(4'd8, 8'h5A);
        pal_wr(4'd13, 8'hE1);
        pal_wr(4'd14, 8'hE2);

        // Reset shadow values: origin 0, 1:1, wrap on, transparency off.
        req(16'd3, 16'd2, 8'hA5, 1'b1, 1'b0);
        req(16'd0, 16'd0, 8'h11, 1'b1, 1'b0);
        req(16'hFFFF, 16'd2, 8'h77, 1'b1, 1'b0);
        idle(10);

        // Border vs wrap.
        load(16'd10, 16'd0, 4'd8, 1'b0, 1'b0);
        req(16'd5, 16'd2, 8'h00, 1'b0, 1'b0);
        idle(10);
        load(16'd10, 16'd0, 4'd8, 1'b1, 1'b0);
        req(16'd5, 16'd2, 8'h3C, 1'b1, 1'b0);
        idle(10);
        load(16'd0, 16'd0, 4'd8, 1'b0, 1'b0);
        req(16'd511, 16'd0, 8'h77, 1'b1, 1'b0);
        req(16'd0, 16'd512, 8'h00, 1'b0, 1'b0);
        req(16'd512, 16'd0, 8'h00, 1'b0, 1'b0);
        req(16'hFFFF, 16'd0, 8'h00, 1'b0, 1'b0);
        idle(10);

        // Transparency.
        load(16'd0, 16'd0, 4'd8, 1'b1, 1'b1);
        req(16'd0, 16'd0, 8'h00, 1'b0, 1'b0);
        req(16'd3, 16'd2, 8'hA5, 1'b1, 1'b0);
        idle(10);
        load(16'd0, 16'd0, 4'd8, 1'b1, 1'b0);
        req(16'd0, 16'd0, 8'h11, 1'b1, 1'b0);
        idle(10);

        // Zoom.
        load(16'd0, 16'd0, 4'd9, 1'b1, 1'b0);
        req(16'd16, 16'd0, 8'hE1, 1'b1, 1'b0);
        req(16'd17, 16'd0, 8'hE2, 1'b1, 1'b0);
        idle(10);
        load(16'd0, 16'd0, 4'd7, 1'b1, 1'b0);
        req(16'd64, 16'd0, 8'hE1, 1'b1, 1'b0);
        idle(10);

        // Staged controls only take effect on ctrl_load.
        load(16'd0, 16'd0, 4'd8, 1'b1, 1'b0);
        @(negedge clk);
        x = 16'd10;
        req(16'd3, 16'd2, 8'hA5, 1'b1, 1'b0);
        req(16'd3, 16'd2, 8'hA5, 1'b1, 1'b1);
        req(16'd3, 16'd2, 8'h5A, 1'b1, 1'b0);
        idle(10);

        // Map write on the edge that reads the same entry returns the old name.
        load(16'd0, 16'd0, 4'd8, 1'b1, 1'b0);
        req(16'd3, 16'd2, 8'hA5, 1'b1, 1'b0);
        idle(2);
        map_wr(12'd0, 8'h82);
        idle(5);
        req(16'd3, 16'd2, 8'h3C, 1'b1, 1'b0);
        idle(12);
      end
      begin : mon
        exp_t e;
        int   lat;
        forever begin
          @(negedge clk);
          if (!reset && mon_en) begin
            vectors++;
            if (pif.out_valid) begin
              if (sb.size() == 0) begin
                fails++;
                $display("FAIL unexpected_out: got color=%h opaque=%b, required no output",
                         pif.color, pif.opaque);
              end else begin
                e   = sb.pop_front();
                lat = int'(cyc) - int'(e.cyc);
                if (pif.color !== e.col || pif.opaque !== e.op || lat != 7) begin
                  fails++;
                  $display("FAIL pixel@%0d: got color=%h opaque=%b latency=%0d, required color=%h opaque=%b latency=7",
                           e.cyc, pif.color, pif.opaque, lat, e.col, e.op);
                end
              end
            end else if (pif.color !== 8'h00 || pif.opaque !== 1'b0) begin
              fails++;
              $display("FAIL bubble: got color=%h opaque=%b, required 00/0", pif.color, pif.opaque);
            end
          end
        end
      end
    join_any

    chk("scoreboard_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
